// File: rtl/el2_dec_gpr_wb_ctl.sv
// el2_dec_gpr_wb_ctl: merges ALU, buffered LSU and buffered DIV results onto the three GPR write ports and tracks pending non-blocking writes
// Ports: clk, rst_l (async active-low); alu_wb_* single-cycle result; lsu_wb_*/div_wb_* valid/ready result streams into DEPTH-entry FIFOs;
// nb_issue_* marks a destination with a non-blocking write outstanding; wen/waddr/wd0..2 drive the GPR file; gpr_busy is the registered scoreboard;
// scan_mode is only meaningful to flop macros and is not used by this logic.
module el2_dec_gpr_wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        push,
  input  logic [4:0]  din_rd,
  input  logic [31:0] din_data,
  input  logic        pop,
  output logic        ready,
  output logic        head_valid,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  assign ready      = cnt_q != CW'(DEPTH);
  assign head_valid = cnt_q != '0;
  assign head_rd    = rd_q[rptr_q];
  assign head_data  = data_q[rptr_q];
  assign cnt_d      = cnt_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr_q]   <= din_rd;
      data_q[wptr_q] <= din_data;
    end
  end
endmodule

module el2_dec_gpr_wb_ctl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  input  logic        lsu_wb_valid,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  output logic        lsu_wb_ready,
  input  logic        div_wb_valid,
  input  logic [4:0]  div_wb_rd,
  input  logic [31:0] div_wb_data,
  output logic        div_wb_ready,
  input  logic        nb_issue_valid,
  input  logic [4:0]  nb_issue_rd,
  output logic        wen0,
  output logic [4:0]  waddr0,
  output logic [31:0] wd0,
  output logic        wen1,
  output logic [4:0]  waddr1,
  output logic [31:0] wd1,
  output logic        wen2,
  output logic [4:0]  waddr2,
  output logic [31:0] wd2,
  output logic [31:1] gpr_busy,
  input  logic        scan_mode
);
  logic        lh, dh, lsu_pop, div_pop;
  logic [4:0]  l_rd, d_rd;
  logic [31:0] l_data, d_data;
  logic [31:1] busy_q, busy_d;
  logic        unused_scan;
  assign unused_scan = scan_mode;
  el2_dec_gpr_wb_fifo #(.DEPTH(DEPTH)) u_lsu (
    .clk        (clk),
    .rst_l      (rst_l),
    .push       (lsu_wb_valid & lsu_wb_ready),
    .din_rd     (lsu_wb_rd),
    .din_data   (lsu_wb_data),
    .pop        (lsu_pop),
    .ready      (lsu_wb_ready),
    .head_valid (lh),
    .head_rd    (l_rd),
    .head_data  (l_data)
  );
  el2_dec_gpr_wb_fifo #(.DEPTH(DEPTH)) u_div (
    .clk        (clk),
    .rst_l      (rst_l),
    .push       (div_wb_valid & div_wb_ready),
    .din_rd     (div_wb_rd),
    .din_data   (div_wb_data),
    .pop        (div_pop),
    .ready      (div_wb_ready),
    .head_valid (dh),
    .head_rd    (d_rd),
    .head_data  (d_data)
  );
  // Fixed priority ALU > LSU > DIV; a head that loses a same-rd collision simply stays put.
  // A head with rd 0 still pops, it just never raises its write enable.
  always_comb begin
    wen0    = alu_wb_valid & (alu_wb_rd != 5'd0);
    waddr0  = wen0 ? alu_wb_rd : '0;
    wd0     = wen0 ? alu_wb_data : '0;
    lsu_pop = lh & ~(wen0 & (waddr0 == l_rd));
    wen1    = lsu_pop & (l_rd != 5'd0);
    waddr1  = wen1 ? l_rd : '0;
    wd1     = wen1 ? l_data : '0;
    div_pop = dh & ~(wen0 & (waddr0 == d_rd)) & ~(wen1 & (waddr1 == d_rd));
    wen2    = div_pop & (d_rd != 5'd0);
    waddr2  = wen2 ? d_rd : '0;
    wd2     = wen2 ? d_data : '0;
  end
  // A fresh issue to the same register outranks the completing write.
  always_comb begin
    busy_d = '0;
    for (int j = 1; j < 32; j++)
      busy_d[j] = (nb_issue_valid & (nb_issue_rd == 5'(j))) |
                  (busy_q[j] & ~((wen1 & (waddr1 == 5'(j))) | (wen2 & (waddr2 == 5'(j)))));
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign gpr_busy = busy_q;
endmodule

// File: doc/el2_dec_gpr_wb_ctl.md
# el2_dec_gpr_wb_ctl

GPR write-back controller that drives the three write ports of the decode-stage register file. It merges single-cycle ALU results with buffered non-blocking load and divider results, guarantees that no two ports write the same GPR in one cycle, and keeps a busy scoreboard of destinations that still have a write outstanding. It sits between the execute/LSU/divider result buses and the GPR file's `wen0..2`, `waddr0..2` and `wd0..2` inputs.

## Interface

**Parameters**
- `DEPTH`, 4: entries in each of the LSU and DIV write-back FIFOs (power of 2, ≥2).

**Ports**
- `clk` in 1: clock.
- `rst_l` in 1: reset, asynchronous, active-low.
- `alu_wb_valid` in 1: ALU result valid this cycle. Always accepted; no ready.
- `alu_wb_rd` in 5: ALU destination.
- `alu_wb_data` in 32: ALU result.
- `lsu_wb_valid` in 1: load result offered.
- `lsu_wb_rd` in 5: load destination.
- `lsu_wb_data` in 32: load data.
- `lsu_wb_ready` out 1: LSU FIFO can accept.
- `div_wb_valid` in 1: divider result offered.
- `div_wb_rd` in 5: divider destination.
- `div_wb_data` in 32: divider result.
- `div_wb_ready` out 1: DIV FIFO can accept.
- `nb_issue_valid` in 1: a non-blocking op (load or divide) issued.
- `nb_issue_rd` in 5: destination of the issued non-blocking op.
- `wen0` out 1, `waddr0` out 5, `wd0` out 32: GPR write port 0 (ALU).
- `wen1` out 1, `waddr1` out 5, `wd1` out 32: GPR write port 1 (LSU).
- `wen2` out 1, `waddr2` out 5, `wd2` out 32: GPR write port 2 (DIV).
- `gpr_busy` out [31:1]: per-GPR scoreboard; bit set means a non-blocking write is pending.
- `scan_mode` in 1: passed to flop macros only.

## Operation

**Port 0 (ALU)**
- `wen0 = alu_wb_valid & (alu_wb_rd != 0)`.
- `waddr0` and `wd0` take the ALU values when `wen0` = 1, otherwise 0.
- Combinational pass-through.

**LSU and DIV FIFOs**
- Each FIFO is `DEPTH` deep, with registered read and write pointers plus a count of width `$clog2(DEPTH)+1`.
- Pointers wrap modulo `DEPTH`.
- Push when `*_wb_valid & *_wb_ready`.
- `*_wb_ready = (count != DEPTH)`. It does not depend on a same-cycle pop; there is no pass-through when full.
- Push and pop in the same cycle leave the count unchanged, and are legal at any count that allows the push.

**Head issue**
- Let `lh` be the LSU head valid flag (LSU count ≠ 0) and `dh` be the DIV head valid flag (DIV count ≠ 0).
- A head entry with rd = 0 pops without asserting its `wen`.
- LSU head pops when `lh & ~(wen0 & waddr0 == lsu_head_rd)`.
- `wen1` = LSU pop and LSU head rd ≠ 0.
- DIV head pops when `dh & ~(wen0 & waddr0 == div_head_rd) & ~(wen1 & waddr1 == div_head_rd)`.
- `wen2` = DIV pop and DIV head rd ≠ 0.
- Priority on a same-rd collision: ALU > LSU > DIV. The losing head is held and retries the next cycle.
- The three `wen` outputs never address the same GPR in one cycle.
- `waddr1`/`wd1` and `waddr2`/`wd2` equal the head entry when the matching `wen` = 1, otherwise 0.

**Scoreboard**
- `busy[j]` is set when `nb_issue_valid & nb_issue_rd == j`, for j ≠ 0.
- `busy[j]` is cleared when `(wen1 & waddr1 == j) | (wen2 & waddr2 == j)`.
- Set and clear of the same j in the same cycle: set wins.
- ALU writes do not affect the scoreboard.
- `gpr_busy` is the registered scoreboard.

## Timing

**Reset**
- All FIFOs empty, pointers 0, scoreboard all 0.
- `wen0..2` follow their equations. With `alu_wb_valid` = 0, all write outputs are 0.
- `lsu_wb_ready` = `div_wb_ready` = 1.
- Reset asserted mid-operation discards all buffered entries and busy bits immediately (asynchronous). No write issues for them after reset releases.

**Latency**
- ALU: 0 cycles.
- LSU/DIV: an entry pushed at edge N is at the head in cycle N+1. Earliest `wen1`/`wen2` is cycle N+1.
- Scoreboard: an issue at cycle N gives `gpr_busy` = 1 from cycle N+1. A write at cycle M gives `gpr_busy` = 0 from cycle M+1, unless re-issued in cycle M.

**Ordering**
- Each FIFO is strictly in order.
- No ordering is enforced between the LSU and DIV FIFOs.

## Test plan

- **Reset and idle.** After reset with all valids low: all `wen`/`waddr`/`wd` = 0, both readies = 1, `gpr_busy` = 0.
- **ALU pass-through.** `alu_wb_valid`=1, rd=5, data=0xDEADBEEF: `wen0`=1, `waddr0`=5, `wd0`=0xDEADBEEF in the same cycle. With rd=0: `wen0`=0.
- **LSU full.**
  - Push 4 loads (rd 1–4, data 0x11–0x44) in back-to-back cycles, with `alu_wb_valid` held at rd=1 for those 4 cycles (blocks drain).
  - Required: `lsu_wb_ready`=0 after the 4th push.
  - Release the ALU: `wen1` writes rd 1, 2, 3, 4 in order, one per cycle. `lsu_wb_ready` returns to 1 the cycle after the first pop.
- **Three-way collision.**
  - LSU head rd=7, DIV head rd=7, ALU rd=7 in the same cycle: only `wen0`=1.
  - Next cycle (ALU idle): `wen1`=1 for rd 7, `wen2`=0.
  - Following cycle: `wen2`=1 for rd 7.
- **Scoreboard.**
  - `nb_issue` rd=9 at cycle 0: `gpr_busy[9]`=1 from cycle 1.
  - Load write for rd 9 at cycle 3 with a simultaneous `nb_issue` rd=9: `busy[9]` stays 1.
  - A later write with no issue clears it the following cycle.
- **Reset mid-stream.** With 2 LSU entries, 1 DIV entry and `busy[3]`=1, pulse `rst_l` low: FIFOs empty, `gpr_busy`=0, and no `wen1`/`wen2` after release.
